// File: rtl/arb_requester.sv
// Requester agent for a 3-way fixed-priority arbiter: queues burst jobs,
// requests the bus, issues one beat per granted cycle, then releases.
//
// Ports:
//   clk, resetn       clock, async active-low reset
//   i_job_valid/len   job offer (len = beats-1), taken when o_job_ready
//   o_job_ready       job queue not full
//   o_req / i_gnt     request to / grant from the arbiter
//   o_beat_valid      bus owned, one data beat this cycle
//   o_beat_last       final beat of the burst
//   o_busy            active or jobs pending
//   o_timeout         pulse: job dropped, grant never arrived
//   o_grant_err       pulse: grant lost before the last beat
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_job_valid,
  input  logic [LEN_W-1:0] i_job_len,
  output logic             o_job_ready,
  output logic             o_req,
  input  logic             i_gnt,
  output logic             o_beat_valid,
  output logic             o_beat_last,
  output logic             o_busy,
  output logic             o_timeout,
  output logic             o_grant_err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int PW1 = PW + 1;
  localparam int WW  = $clog2(TIMEOUT);

  localparam logic [PW:0]      P_ONE  = PW1'(1);
  localparam logic [WW-1:0]    W_ONE  = WW'(1);
  localparam logic [WW-1:0]    W_MAX  = WW'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] L_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] L_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OWN  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic [LEN_W-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_beat;
  logic [WW-1:0]    r_wait;
  logic             r_req;
  logic             r_live;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_wait_clr;
  logic w_wait_inc;
  logic w_beat_ld;
  logic w_beat_dec;
  logic w_bv;
  logic w_bl;
  logic w_to;
  logic w_ge;

  // Extra pointer bit separates full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) &&
                   (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_push  = i_job_valid && o_job_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= i_job_len;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_pop      = 1'b0;
    w_wait_clr = 1'b0;
    w_wait_inc = 1'b0;
    w_beat_ld  = 1'b0;
    w_beat_dec = 1'b0;
    w_bv       = 1'b0;
    w_bl       = 1'b0;
    w_to       = 1'b0;
    w_ge       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_wait_clr = 1'b1;
          w_nstate   = S_REQ;
        end
      end
      S_REQ: begin
        // A grant arriving on the last wait cycle still wins.
        if (i_gnt) begin
          w_beat_ld = 1'b1;
          w_nstate  = S_OWN;
        end else if (r_wait == W_MAX) begin
          w_to     = 1'b1;
          w_nstate = S_REL;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_OWN: begin
        if (i_gnt) begin
          w_bv = 1'b1;
          if (r_beat == L_ZERO) begin
            w_bl     = 1'b1;
            w_nstate = S_REL;
          end else begin
            w_beat_dec = 1'b1;
          end
        end else begin
          w_ge     = 1'b1;
          w_nstate = S_REL;
        end
      end
      S_REL: begin
        // Hold off re-requesting until the old grant is gone.
        if (!i_gnt) begin
          w_nstate = S_IDLE;
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_wait  <= '0;
      r_req   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      // Own flop so req cannot glitch on multi-bit state changes.
      r_req   <= (w_nstate == S_REQ) || (w_nstate == S_OWN);
      r_live  <= 1'b1;
      if (w_push) begin
        r_wptr <= r_wptr + P_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + P_ONE;
        r_len  <= r_mem[r_rptr[PW-1:0]];
      end
      if (w_wait_clr) begin
        r_wait <= '0;
      end else if (w_wait_inc) begin
        r_wait <= r_wait + W_ONE;
      end
      if (w_beat_ld) begin
        r_beat <= r_len;
      end else if (w_beat_dec) begin
        r_beat <= r_beat - L_ONE;
      end
    end
  end

  assign o_job_ready  = r_live && !w_full;
  assign o_req        = r_req;
  assign o_beat_valid = w_bv;
  assign o_beat_last  = w_bl;
  assign o_busy       = (r_state != S_IDLE) || !w_empty;
  assign o_timeout    = w_to;
  assign o_grant_err  = w_ge;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios plus random traffic,
// every cycle compared with a queue-based behavioural model.
module tb_arb_requester;

  localparam int LW = 4;
  localparam int DP = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          job_valid = 1'b0;
  logic [LW-1:0] job_len = '0;
  logic          gnt = 1'b0;
  logic          job_ready;
  logic          req;
  logic          beat_valid;
  logic          beat_last;
  logic          busy;
  logic          timeout;
  logic          grant_err;

  always #5 clk = ~clk;

  arb_requester #(
    .LEN_W(LW),
    .DEPTH(DP),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .i_job_valid (job_valid),
    .i_job_len   (job_len),
    .o_job_ready (job_ready),
    .o_req       (req),
    .i_gnt       (gnt),
    .o_beat_valid(beat_valid),
    .o_beat_last (beat_last),
    .o_busy      (busy),
    .o_timeout   (timeout),
    .o_grant_err (grant_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for grant, 2 bursting, 3 releasing.
  int ph;
  int q[$];
  int cur;
  int waited;
  int done;
  bit live;

  function automatic bit acc_now();
    return job_valid && live && (q.size() < DP);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph = 0;
      q.delete();
      cur = 0;
      waited = 0;
      done = 0;
      live = 0;
    end else begin
      bit acc;
      acc = acc_now();
      case (ph)
        0: if (q.size() > 0) begin
          cur = q.pop_front();
          waited = 0;
          ph = 1;
        end
        1: if (gnt) begin
          done = 0;
          ph = 2;
        end else if (waited == TO - 1) begin
          ph = 3;
        end else begin
          waited++;
        end
        2: if (!gnt || done == cur) ph = 3;
           else done++;
        default: if (!gnt) ph = 0;
      endcase
      if (acc) q.push_back(int'(job_len));
      live = 1;
    end
  end

  always @(negedge clk) begin
    chk("req", req, (ph == 1 || ph == 2));
    chk("beat_valid", beat_valid, (ph == 2 && gnt));
    chk("beat_last", beat_last, (ph == 2 && gnt && done == cur));
    chk("busy", busy, (ph != 0 || q.size() != 0));
    chk("timeout", timeout, (ph == 1 && !gnt && waited == TO - 1));
    chk("grant_err", grant_err, (ph == 2 && !gnt));
    chk("job_ready", job_ready, (live && q.size() < DP));
  end

  // Arbiter stand-in: grant follows the model's request after lag cycles.
  int gmode = 0;
  int lag = 2;
  int kill = 0;
  logic [7:0] hist = '0;

  always @(posedge clk) begin
    #1;
    hist = {hist[6:0], (ph == 1 || ph == 2)};
    if (gmode == 1) gnt = 1'b0;
    else begin
      gnt = hist[lag];
      if (kill > 0 && $urandom_range(0, 99) < kill) gnt = 1'b0;
    end
  end

  task automatic push(int len);
    @(posedge clk);
    #1;
    job_valid = 1'b1;
    job_len = LW'(len);
    @(posedge clk);
    #1;
    job_valid = 1'b0;
  endtask

  task automatic drain(string nm);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(nm, busy, 0);
  endtask

  logic [10:0] v_rq, v_bv, v_bl, v_bz, v_to;

  task automatic rec11();
    v_rq = '0; v_bv = '0; v_bl = '0; v_bz = '0; v_to = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      v_rq[k] = req;
      v_bv[k] = beat_valid;
      v_bl[k] = beat_last;
      v_bz[k] = busy;
      v_to[k] = timeout;
    end
  endtask

  initial begin
    int acc, nb, ge, bl, seen, gap, pv;
    int lens[5];
    lens = '{1, 3, 0, 2, 4};

    repeat (2) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_beat", beat_valid, 0);
    chk("rst_to", timeout, 0);
    chk("rst_gerr", grant_err, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_ready", job_ready, 1);

    // 1: len=2, grant 2 cycles after req
    gmode = 0; lag = 2; kill = 0;
    push(2);
    rec11();
    chk("t1_req", v_rq, 11'h07E);
    chk("t1_bv", v_bv, 11'h070);
    chk("t1_bl", v_bl, 11'h040);
    chk("t1_busy", v_bz, 11'h3FF);

    // 2: grant never arrives
    gmode = 1;
    push(0);
    rec11();
    chk("t2_req", v_rq, 11'h1FE);
    chk("t2_to", v_to, 11'h100);
    chk("t2_busy", v_bz, 11'h3FF);

    // 3: five jobs offered back-to-back while starved
    @(posedge clk);
    #1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      job_valid = 1'b1;
      job_len = LW'(lens[acc % 5]);
      @(negedge clk);
      if (job_ready) acc++;
      @(posedge clk);
      #1;
    end
    job_valid = 1'b0;
    chk("t3_accepts", acc, 5);
    chk("t3_full", job_ready, 0);
    gmode = 0;
    drain("t3_drain");

    // 4: second job waits for the stale grant to fall
    push(1);
    push(1);
    seen = 0; gap = 0;
    for (int i = 0; i < 200 && seen < 3; i++) begin
      @(negedge clk);
      if (seen == 0 && req) seen = 1;
      else if (seen == 1 && !req) begin
        seen = 2; gap = 1;
      end else if (seen == 2) begin
        if (req) seen = 3;
        else gap++;
      end
    end
    chk("t4_gap", gap, 4);
    drain("t4_drain");

    // 5: grant pulled after two beats
    push(5);
    nb = 0; ge = 0; bl = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (beat_valid) nb++;
      if (beat_last) bl++;
      if (grant_err) ge++;
      if (nb == 2 && gmode == 0) gmode = 1;
    end
    gmode = 0;
    chk("t5_beats", nb, 2);
    chk("t5_gerr", ge, 1);
    chk("t5_last", bl, 0);
    drain("t5_drain");

    // 6: reset in the middle of a burst
    push(7);
    push(7);
    push(7);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (beat_valid) break;
    end
    chk("t6_own", beat_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_req", req, 0);
    chk("t6_bv", beat_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", job_ready, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_ready_rel", job_ready, 1);
    chk("t6_busy_rel", busy, 0);

    // random traffic
    for (int s = 0; s < 60; s++) begin
      gmode = ($urandom_range(0, 9) == 0) ? 1 : 0;
      lag = $urandom_range(2, 4);
      kill = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
      pv = $urandom_range(5, 60);
      for (int c = 0; c < 50; c++) begin
        @(posedge clk);
        #1;
        job_valid = ($urandom_range(0, 99) < pv);
        job_len = LW'($urandom);
      end
      job_valid = 1'b0;
    end
    gmode = 0; kill = 0; lag = 2;
    drain("rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
